// File: rtl/run_sequencer.sv
// run_sequencer: boot/run controller for the 8-bit core.
// Streams an input image into data memory, releases the core from reset,
// counts core cycles until done or timeout, then streams a data-memory
// window back out. Owns the data-memory port whenever the core is in reset.
module run_sequencer #(
   parameter int unsigned LOAD_BASE = 0,
   parameter int unsigned LOAD_LEN  = 64,
   parameter int unsigned DUMP_BASE = 64,
   parameter int unsigned DUMP_LEN  = 64,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        core_reset,
   input  logic        core_done,
   output logic        mem_sel,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        timeout_err,
   output logic [15:0] cycle_count
);

   // Base addresses wrap modulo 256; last-index values allow LEN up to 256.
   localparam logic [7:0]  LOAD_BASE8 = 8'(LOAD_BASE % 256);
   localparam logic [7:0]  DUMP_BASE8 = 8'(DUMP_BASE % 256);
   localparam logic [7:0]  LOAD_LAST  = 8'((LOAD_LEN == 0) ? 0 : LOAD_LEN - 1);
   localparam logic [7:0]  DUMP_LAST  = 8'((DUMP_LEN == 0) ? 0 : DUMP_LEN - 1);
   localparam logic [15:0] TIMEOUT16  = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DUMP,
      S_FINISH
   } state_t;

   state_t      state;
   logic [7:0]  idx;
   logic [15:0] count_next;

   assign count_next = cycle_count + 16'd1;

   // Sequence control: state, byte index, run cycle counter, timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         cycle_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FINISH: begin
               if (start) begin
                  idx         <= '0;
                  cycle_count <= '0;
                  timeout_err <= 1'b0;
                  state       <= (LOAD_LEN == 0) ? S_RUN : S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  if (idx == LOAD_LAST) begin
                     idx   <= '0;
                     state <= S_RUN;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            S_RUN: begin
               // done takes priority over the timeout and is not counted
               if (core_done) begin
                  idx   <= '0;
                  state <= (DUMP_LEN == 0) ? S_FINISH : S_DUMP;
               end else if (count_next == TIMEOUT16) begin
                  cycle_count <= count_next;
                  timeout_err <= 1'b1;
                  idx         <= '0;
                  state       <= (DUMP_LEN == 0) ? S_FINISH : S_DUMP;
               end else begin
                  cycle_count <= count_next;
               end
            end
            S_DUMP: begin
               if (out_ready) begin
                  if (idx == DUMP_LAST) begin
                     idx   <= '0;
                     state <= S_FINISH;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            default: begin
               idx   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake and memory-port outputs decoded from state and index.
   always_comb begin
      in_ready   = 1'b0;
      core_reset = 1'b1;
      mem_sel    = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      busy       = 1'b0;
      case (state)
         S_LOAD: begin
            in_ready  = 1'b1;
            mem_addr  = LOAD_BASE8 + idx;
            mem_wdata = in_data;
            mem_we    = in_valid;
            busy      = 1'b1;
         end
         S_RUN: begin
            core_reset = 1'b0;
            mem_sel    = 1'b0;
            busy       = 1'b1;
         end
         S_DUMP: begin
            mem_addr  = DUMP_BASE8 + idx;
            out_valid = 1'b1;
            out_data  = mem_rdata;
            busy      = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Testbench for run_sequencer: memory and core models, random load images,
// random core run lengths, dump stalls, timeout and mid-run reset.
module tb_run_sequencer;

   localparam int unsigned LB = 250;
   localparam int unsigned LL = 4;
   localparam int unsigned DB = 254;
   localparam int unsigned DL = 4;
   localparam int unsigned TO = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        core_reset;
   logic        core_done;
   logic        mem_sel;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        busy;
   logic        timeout_err;
   logic [15:0] cycle_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [7:0]  mem [0:255];
   int unsigned run_cyc = 0;
   int unsigned done_after = 1000;

   run_sequencer #(
      .LOAD_BASE(LB),
      .LOAD_LEN (LL),
      .DUMP_BASE(DB),
      .DUMP_LEN (DL),
      .TIMEOUT  (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .core_reset (core_reset),
      .core_done  (core_done),
      .mem_sel    (mem_sel),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .timeout_err(timeout_err),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Combinational-read data memory.
   assign mem_rdata = mem[mem_addr];

   // Core model: raises done once it has run done_after un-reset cycles.
   assign core_done = !core_reset && (run_cyc >= done_after);

   // Memory writes from the sequencer; the core copies the loaded image
   // (xor 0xA5) into the dump window during its first four cycles.
   always @(posedge clk) begin
      if (mem_sel && mem_we)
         mem[mem_addr] <= mem_wdata;
      if (!core_reset) begin
         if (run_cyc < 4)
            mem[8'(DB + run_cyc)] <= mem[8'(LB + run_cyc)] ^ 8'hA5;
         run_cyc <= run_cyc + 1;
      end else begin
         run_cyc <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
      check({tag, "_mem_sel"},    32'(mem_sel),    32'd1);
      check({tag, "_in_ready"},   32'(in_ready),   32'd0);
      check({tag, "_out_valid"},  32'(out_valid),  32'd0);
      check({tag, "_mem_we"},     32'(mem_we),     32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
   endtask

   // One full start/load/run/dump sequence. d = core run length before done;
   // abort_at != 0 asserts reset in that RUN cycle instead of finishing.
   task automatic do_sequence(input int unsigned d, input bit gaps, input int unsigned abort_at);
      logic [7:0]  ld [4];
      int unsigned acc, cyc, run_n, stall;
      int unsigned exp_count, exp_run_n;
      bit          exp_err;

      for (int i = 0; i < 4; i++) ld[i] = 8'($urandom);
      done_after = d;
      exp_err    = (d >= TO);
      exp_count  = exp_err ? TO : d;
      exp_run_n  = exp_err ? TO : d + 1;

      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      check("pre_start_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;

      // LOAD
      acc = 0;
      cyc = 0;
      while (acc < LL && cyc < 50) begin
         in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
         in_data  = ld[acc];
         @(negedge clk);
         if (cyc == 0) begin
            check("start_clr_count", 32'(cycle_count), 32'd0);
            check("start_clr_err",   32'(timeout_err), 32'd0);
         end
         check("load_ready",      32'(in_ready),   32'd1);
         check("load_we",         32'(mem_we),     32'(in_valid));
         check("load_addr",       32'(mem_addr),   (LB + acc) % 256);
         check("load_core_reset", 32'(core_reset), 32'd1);
         check("load_busy",       32'(busy),       32'd1);
         if (in_valid)
            check("load_wdata", 32'(mem_wdata), 32'(ld[acc]));
         @(posedge clk); #1;
         if (in_valid) acc++;
         cyc++;
      end
      in_valid = 1'b0;
      check("load_accepts", acc, LL);
      check("load_cycles",  cyc, gaps ? 2 * LL - 1 : LL);

      // RUN
      @(negedge clk);
      check("run_core_reset", 32'(core_reset), 32'd0);
      check("run_mem_sel",    32'(mem_sel),    32'd0);
      check("run_mem_we",     32'(mem_we),     32'd0);
      check("run_busy",       32'(busy),       32'd1);
      run_n = 0;
      while (!core_reset && run_n < 200) begin
         run_n++;
         if (abort_at != 0 && run_n == abort_at) begin
            reset = 1'b1;
            #1;
            check("abort_count", 32'(cycle_count), 32'd0);
            check("abort_err",   32'(timeout_err), 32'd0);
            check_idle_outputs("abort");
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check_idle_outputs("after_abort");
            return;
         end
         start = (run_n == 2);
         @(negedge clk);
      end
      start = 1'b0;
      check("run_cycles",  run_n, exp_run_n);
      check("cycle_count", 32'(cycle_count), exp_count);
      check("timeout_err", 32'(timeout_err), 32'(exp_err));

      // DUMP
      for (int k = 0; k < 4; k++) begin
         stall = (k == 1) ? 3 : $urandom_range(0, 2);
         for (int unsigned s = 0; s <= stall; s++) begin
            out_ready = (s == stall);
            check("dump_valid",      32'(out_valid),  32'd1);
            check("dump_addr",       32'(mem_addr),   (DB + k) % 256);
            check("dump_data",       32'(out_data),   32'(ld[k] ^ 8'hA5));
            check("dump_core_reset", 32'(core_reset), 32'd1);
            check("dump_mem_sel",    32'(mem_sel),    32'd1);
            check("dump_mem_we",     32'(mem_we),     32'd0);
            @(negedge clk);
         end
      end
      out_ready = 1'b0;

      // FINISH
      check_idle_outputs("finish");
      check("finish_count", 32'(cycle_count), exp_count);
      check("finish_err",   32'(timeout_err), 32'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      reset     = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      check("rst_count", 32'(cycle_count), 32'd0);
      check("rst_err",   32'(timeout_err), 32'd0);
      check_idle_outputs("rst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("idle_hold");

      do_sequence(37, 1'b0, 0);     // done path
      do_sequence(1000, 1'b1, 0);   // timeout with gapped load
      do_sequence(39, 1'b0, 0);     // done coincides with timeout boundary
      do_sequence(40, 1'b1, 0);     // first length that times out
      do_sequence(1000, 1'b0, 5);   // reset mid-run
      for (int n = 0; n < 8; n++)
         do_sequence($urandom_range(4, 60), 1'($urandom), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
